// File: rtl/rv_ifetch.sv
// rv_ifetch: halfword-aligned instruction fetch/align stage with a 2-entry word buffer.
// Define RV_IFETCH_PREFETCH_EN to prefetch the next sequential word on a buffer hit.
module rv_ifetch #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] c_adr,
  input  logic          c_re,
  output logic [31:0]   c_dr,
  output logic          c_rdy,
  input  logic          flush,
  output logic [AW-1:0] m_adr,
  output logic          m_re,
  input  logic [31:0]   m_dr,
  input  logic          m_rdy
);
  localparam int TW = AW - 2;
`ifdef RV_IFETCH_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, CHECK, FILL, PF} state_t;
  logic rv_q, rv_d, pmiss, pv;
  logic [TW-1:0] pw;
`else
  typedef enum logic [1:0] {IDLE, CHECK, FILL} state_t;
`endif
  state_t st_q, st_d;
  logic [AW-1:1] req_q, req_d;
  logic [1:0][TW-1:0] tag_q, tag_d;
  logic [1:0][31:0] dat_q, dat_d;
  logic [1:0] val_q, val_d, h0, h1, oh;
  logic lru_q, lru_d, vic_q, vic_d, fl_q, fl_d, nd1, hit, vic, wv;
  logic [TW-1:0] fw_q, fw_d, w0, w1, mw;
  logic [31:0] cdr_q, d0, d1, win;
  logic unused_c_adr0;
  assign unused_c_adr0 = c_adr[0];
  assign w0  = req_q[AW-1:2];
  assign w1  = w0 + TW'(1);
  assign nd1 = req_q[1];
  assign h0  = {val_q[1] && tag_q[1] == w0, val_q[0] && tag_q[0] == w0};
  assign h1  = {val_q[1] && tag_q[1] == w1, val_q[0] && tag_q[0] == w1};
  assign hit = |h0 && (!nd1 || |h1);
  assign d0  = h0[0] ? dat_q[0] : dat_q[1];
  assign d1  = h1[0] ? dat_q[0] : dat_q[1];
  assign win = nd1 ? {d1[15:0], d0[31:16]} : d0;
  // Victim avoids the entry holding the other needed word, else falls back to LRU.
  assign oh  = |h0 ? h0 : (nd1 ? h1 : 2'b00);
  assign vic = oh[0] ? 1'b1 : (oh[1] ? 1'b0 : lru_q);
  assign mw  = |h0 ? w1 : w0;
  assign wv  = !(fl_q || flush);
  assign c_dr = c_rdy ? win : cdr_q;
`ifdef RV_IFETCH_PREFETCH_EN
  assign pw    = (nd1 ? w1 : w0) + TW'(1);
  assign pmiss = !((val_q[0] && tag_q[0] == pw) || (val_q[1] && tag_q[1] == pw));
  assign pv    = nd1 ? h1[0] : h0[0];
`endif
  always_comb begin
    st_d = st_q;
    req_d = req_q;
    tag_d = tag_q;
    dat_d = dat_q;
    val_d = flush ? 2'b00 : val_q;
    lru_d = lru_q;
    vic_d = vic_q;
    fw_d = fw_q;
    fl_d = 1'b0;
    c_rdy = 1'b0;
    m_re = 1'b0;
    m_adr = '0;
`ifdef RV_IFETCH_PREFETCH_EN
    rv_d = rv_q;
`endif
    case (st_q)
      IDLE: begin
        req_d = c_re ? c_adr[AW-1:1] : req_q;
        st_d = c_re ? CHECK : IDLE;
      end
      CHECK: begin
        if (hit) begin
          c_rdy = 1'b1;
          req_d = c_re ? c_adr[AW-1:1] : req_q;
          st_d = c_re ? CHECK : IDLE;
`ifdef RV_IFETCH_PREFETCH_EN
          if (pmiss) begin
            st_d = PF;
            fw_d = pw;
            vic_d = pv;
            rv_d = c_re;
          end
`endif
        end else begin
          st_d = FILL;
          fw_d = mw;
          vic_d = vic;
        end
      end
      FILL: begin
        m_re = 1'b1;
        m_adr = {fw_q, 2'b00};
        fl_d = fl_q || flush;
        if (m_rdy) begin
          dat_d[vic_q] = m_dr;
          tag_d[vic_q] = fw_q;
          val_d[vic_q] = wv;
          lru_d = ~vic_q;
          fl_d = 1'b0;
          // A straddle missing both words chains straight into the second fill.
          if (wv && nd1 && fw_q == w0 && !(|h1)) begin
            fw_d = w1;
            vic_d = ~vic_q;
          end else begin
            st_d = CHECK;
          end
        end
      end
`ifdef RV_IFETCH_PREFETCH_EN
      PF: begin
        m_re = 1'b1;
        m_adr = {fw_q, 2'b00};
        fl_d = fl_q || flush;
        if (rv_q && hit) begin
          c_rdy = 1'b1;
          req_d = c_re ? c_adr[AW-1:1] : req_q;
          rv_d = c_re;
        end else if (!rv_q && c_re) begin
          req_d = c_adr[AW-1:1];
          rv_d = 1'b1;
        end
        if (m_rdy) begin
          dat_d[vic_q] = m_dr;
          tag_d[vic_q] = fw_q;
          val_d[vic_q] = wv;
          lru_d = ~vic_q;
          fl_d = 1'b0;
          st_d = rv_d ? CHECK : IDLE;
        end
      end
`endif
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      req_q <= '0;
      tag_q <= '0;
      dat_q <= '0;
      val_q <= 2'b00;
      lru_q <= 1'b0;
      vic_q <= 1'b0;
      fw_q <= '0;
      fl_q <= 1'b0;
      cdr_q <= '0;
`ifdef RV_IFETCH_PREFETCH_EN
      rv_q <= 1'b0;
`endif
    end else begin
      st_q <= st_d;
      req_q <= req_d;
      tag_q <= tag_d;
      dat_q <= dat_d;
      val_q <= val_d;
      lru_q <= lru_d;
      vic_q <= vic_d;
      fw_q <= fw_d;
      fl_q <= fl_d;
      cdr_q <= c_dr;
`ifdef RV_IFETCH_PREFETCH_EN
      rv_q <= rv_d;
`endif
    end
  end
endmodule

// File: doc/rv_ifetch.md
Name: rv_ifetch

Overview:
- Instruction fetch/align stage between the rv32emc core fetch port and a 32-bit word-wide instruction memory.
- Accepts halfword-aligned fetch addresses, including RVC targets and 32-bit instructions that straddle a word boundary.
- Returns a 32-bit window starting at the requested halfword: {halfword@A+2, halfword@A}.
- Holds a 2-entry word buffer so sequential and straddling fetches reuse words already read.

Parameters:
- AW, 32, address width; tag = adr[AW-1:2].

Ports:
- clk, input, 1, clock; all state on rising edge.
- reset, input, 1, synchronous active-high reset.
- c_adr, input, AW, core fetch address; bit0 ignored (treated as 0).
- c_re, input, 1, core fetch request.
- c_dr, output, 32, aligned instruction window for the accepted request.
- c_rdy, output, 1, c_dr valid; the core holds c_adr stable while c_rdy=0.
- flush, input, 1, invalidate both buffer entries (fence.i).
- m_adr, output, AW, word-aligned memory read address (bits[1:0]=0).
- m_re, output, 1, memory read request; held with m_adr stable until m_rdy.
- m_dr, input, 32, memory read data, valid when m_rdy=1.
- m_rdy, input, 1, memory read done; one outstanding read only.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; both entries invalid; LRU=0.
  - c_rdy=0, c_dr=0, m_re=0, m_adr=0.
  - An in-flight memory response is ignored: m_rdy has no effect in IDLE or CHECK.
- Words needed by request R:
  - w0 = R[AW-1:2].
  - w1 = w0+1, needed only when R[1]=1; w0+1 wraps modulo 2^(AW-2).
  - Hit = every needed word is in a valid entry whose tag matches.
- IDLE: when c_re=1, register req_adr=c_adr and go to CHECK. c_rdy=0.
- CHECK, hit:
  - c_rdy=1 combinationally.
  - c_dr = R[1] ? {w1[15:0], w0[31:16]} : w0.
  - Same cycle: if c_re=1, accept the next c_adr and stay in CHECK; else go to IDLE.
- CHECK, miss:
  - c_rdy=0.
  - Select the lowest missing word (w0 before w1).
  - Victim = the entry not holding the other needed word; if neither entry holds it, the entry not most recently written (LRU).
  - Go to FILL.
- FILL:
  - m_re=1, m_adr={missing word,2'b00}.
  - On m_rdy=1: write m_dr and the tag into the victim, set it valid, update LRU, return to CHECK.
  - A fully missing straddling request therefore takes two FILLs.
- Latency with a 1-cycle memory (m_rdy the cycle after m_re rises):
  - Hit: c_rdy the cycle after acceptance.
  - One-word miss: c_rdy 4 cycles after acceptance.
  - Two-word miss: 6 cycles.
- c_dr holds its last value while c_rdy=0.
- flush:
  - Clears both valid bits at the edge; the current request resolves as a miss.
  - flush during FILL: the fill completes but the entry is written invalid, and CHECK re-fetches.
  - flush together with a CHECK hit: the hit data is still returned that cycle.
- c_re=0 in CHECK-hit: go to IDLE; no memory activity.
- Requests are never accepted in FILL.

Optional Feature:
- Macro: RV_IFETCH_PREFETCH_EN.
- With the macro defined:
  - In a CHECK hit, if word p = (highest needed word)+1 is not buffered, start a prefetch into the entry not used by the current request.
  - New state PF: m_re=1 for p, and requests continue to be accepted and served from the other entry.
  - A request needing p waits (c_rdy=0) until m_rdy, then is served the following cycle.
  - A request missing on any other word waits for PF to complete, then does a normal FILL.
  - flush in PF discards the prefetched word.
- Without the macro: no PF state; memory is read only on demand misses. Straight-line code stalls once per new word.

Test Plan:
- Memory holds word 0x00000000=0x11112222, 0x00000004=0x33334444; 1-cycle memory.
- Reset with c_re=1 → c_rdy=0 and m_re=0 throughout reset; first request accepted the cycle after reset deasserts.
- c_adr=0x0 cold → m_re with m_adr=0x0; c_rdy 4 cycles after acceptance with c_dr=0x11112222. Repeat c_adr=0x0 → c_rdy the next cycle with no m_re.
- Straddle after cold reset, c_adr=0x2 → FILL 0x0 then FILL 0x4; c_dr=0x44441111 six cycles after acceptance.
- With both words buffered, request 0x8 → victim is the LRU entry (word 0). A following 0x4 hits; a following 0x0 misses.
- flush pulsed in CHECK-hit of 0x0 → data 0x11112222 still returned; next 0x0 request re-reads memory.
- Reset asserted during FILL, with m_rdy arriving the next cycle → buffer stays invalid, m_re=0, no c_rdy.
- With RV_IFETCH_PREFETCH_EN: cold 0x0 then 0x4 → prefetch of 0x4 issued after the 0x0 hit; the 0x4 request then completes without a demand FILL.
